// File: rtl/wb_mem_responder.sv
// Wishbone B4 responder backed by a small word RAM: registered ack, wrap bursts, wait injection.
// Optional: define WB_RESP_OOR_ERR_EN to terminate out-of-range beats with wb_err instead of ack.
module wb_mem_responder #(
   parameter int          DEPTH_LOG2 = 4,
   parameter logic [29:0] BASE_ADR   = 30'h400
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [29:0] wb_adr,
   input  logic [31:0] wb_dat_w,
   output logic [31:0] wb_dat_r,
   input  logic [3:0]  wb_sel,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [2:0]  wb_cti,
   input  logic [1:0]  wb_bte,
   output logic        wb_ack,
   output logic        wb_err,
   input  logic        wait_req
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef WB_RESP_OOR_ERR_EN
   localparam bit OorErr = 1'b1;
`else
   localparam bit OorErr = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RESP, BURST} state_t;

   state_t      state_q;
   logic        ack_q;
   logic        err_q;
   logic        burst_q;
   logic [31:0] datR_q;
   logic [29:0] curAdr_q;
   logic [1:0]  bte_q;
   logic [31:0] ram_q [DEPTH];

   logic        accept;
   logic        mismatch;
   logic        termOk;
   logic        beatMore;
   logic        waiting;
   logic        loadInRange;
   logic        loadErr;
   logic [29:0] pred;
   logic [29:0] loadAdr;
   logic [29:0] loadOff;
   logic [31:0] loadWord;

   function automatic logic [29:0] nextAdr(input logic [29:0] adr, input logic [1:0] bte);
      case (bte)
         2'b01:   nextAdr = {adr[29:2], adr[1:0] + 2'd1};
         2'b10:   nextAdr = {adr[29:3], adr[2:0] + 3'd1};
         2'b11:   nextAdr = {adr[29:4], adr[3:0] + 4'd1};
         default: nextAdr = adr + 30'd1;
      endcase
   endfunction

   // curAdr_q always names the beat whose termination is (or will next be) on the bus,
   // so one address mux serves fresh accepts, wait-state resumes and prefetches.
   always_comb begin
      accept   = wb_cyc & wb_stb & ~wait_req;
      waiting  = (state_q == BURST) & ~(ack_q | err_q);
      pred     = nextAdr(curAdr_q, bte_q);
      mismatch = (state_q == BURST) & (ack_q | err_q) & (wb_adr != curAdr_q);
      termOk   = wb_cyc & ~mismatch;
      beatMore = wb_stb & ~wb_we & (wb_cti == 3'b010);
      if (state_q == IDLE)
         loadAdr = wb_adr;
      else if (waiting)
         loadAdr = curAdr_q;
      else
         loadAdr = pred;
      loadOff     = loadAdr - BASE_ADR;
      loadInRange = (loadAdr >= BASE_ADR) && (loadOff < 30'(DEPTH));
      loadErr     = ~loadInRange & OorErr;
      loadWord    = loadInRange ? ram_q[loadOff[DEPTH_LOG2-1:0]] : 32'h0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         burst_q  <= 1'b0;
         datR_q   <= '0;
         curAdr_q <= '0;
         bte_q    <= '0;
         for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
      end else if (!wb_cyc) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               if (accept) begin
                  ack_q    <= ~loadErr;
                  err_q    <= loadErr;
                  burst_q  <= (wb_cti == 3'b010) & ~wb_we & ~loadErr;
                  curAdr_q <= wb_adr;
                  bte_q    <= wb_bte;
                  state_q  <= RESP;
                  if (!wb_we)
                     datR_q <= loadWord;
                  else if (loadInRange)
                     for (int i = 0; i < 4; i++)
                        if (wb_sel[i])
                           ram_q[loadOff[DEPTH_LOG2-1:0]][8*i +: 8] <= wb_dat_w[8*i +: 8];
               end
            end
            default: begin
               if (waiting) begin
                  // A stalled burst resumes only on the predicted address; anything else restarts in IDLE.
                  if (accept) begin
                     if (wb_adr == curAdr_q) begin
                        ack_q   <= ~loadErr;
                        err_q   <= loadErr;
                        datR_q  <= loadWord;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end else if (err_q || mismatch || !burst_q || !beatMore) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
                  err_q   <= 1'b0;
               end else if (wait_req) begin
                  state_q  <= BURST;
                  ack_q    <= 1'b0;
                  err_q    <= 1'b0;
                  curAdr_q <= pred;
               end else begin
                  state_q  <= BURST;
                  ack_q    <= ~loadErr;
                  err_q    <= loadErr;
                  datR_q   <= loadWord;
                  curAdr_q <= pred;
               end
            end
         endcase
      end
   end

   assign wb_ack   = ack_q & termOk;
   assign wb_err   = OorErr ? (err_q & termOk) : 1'b0;
   assign wb_dat_r = datR_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Scoreboard bench for wb_mem_responder: directed classic, burst, wait, mismatch and range vectors.
// Expectations follow WB_RESP_OOR_ERR_EN when it is defined for the build.
module tb_wb_mem_responder;

`ifdef WB_RESP_OOR_ERR_EN
   localparam bit OorErr = 1'b1;
`else
   localparam bit OorErr = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [29:0] adr = '0;
   logic [31:0] datW = '0;
   logic [31:0] wb_dat_r;
   logic [3:0]  sel = '0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we = 1'b0;
   logic [2:0]  cti = '0;
   logic [1:0]  bte = '0;
   logic        wb_ack;
   logic        wb_err;
   logic        waitReq = 1'b0;

   typedef struct {
      logic        err;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   int   checks = 0;
   int   errors = 0;

   wb_mem_responder dut (
      .clock    (clock),
      .reset    (reset),
      .wb_adr   (adr),
      .wb_dat_w (datW),
      .wb_dat_r (wb_dat_r),
      .wb_sel   (sel),
      .wb_cyc   (cyc),
      .wb_stb   (stb),
      .wb_we    (we),
      .wb_cti   (cti),
      .wb_bte   (bte),
      .wb_ack   (wb_ack),
      .wb_err   (wb_err),
      .wait_req (waitReq)
   );

   always #5 clock = ~clock;

   // Every termination pops the oldest expected response; ack/err must be exclusive.
   always @(negedge clock) begin
      if (wb_ack === 1'b1 || wb_err === 1'b1) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_term: ack=%0b err=%0b data=%h, required no termination",
                     wb_ack, wb_err, wb_dat_r);
         end else begin
            monE = expQ.pop_front();
            if ({wb_ack, wb_err} !== {~monE.err, monE.err} || (monE.chk && wb_dat_r !== monE.data)) begin
               errors++;
               $display("[TB] FAIL response: ack=%0b err=%0b data=%h, required ack=%0b err=%0b data=%h",
                        wb_ack, wb_err, wb_dat_r, ~monE.err, monE.err, monE.data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic applyStimulus(input bit c, input bit s, input bit w, input logic [29:0] a,
                                input logic [2:0] ct, input logic [1:0] b, input logic [3:0] se,
                                input logic [31:0] d, input bit wr);
      @(posedge clock);
      #1;
      cyc = c; stb = s; we = w; adr = a; cti = ct; bte = b; sel = se; datW = d; waitReq = wr;
   endtask

   task automatic idleBus();
      applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 3'b000, 2'b00, 4'h0, 32'h0, 1'b0);
   endtask

   task automatic checkOutput(input string name, input bit expAck);
      @(negedge clock);
      checks++;
      if (wb_ack !== expAck) begin
         errors++;
         $display("[TB] FAIL %s: ack=%0b, required %0b", name, wb_ack, expAck);
      end
   endtask

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   // Single classic beat; termination must land exactly one cycle after wait_req releases.
   task automatic classicXfer(input string name, input bit w, input logic [29:0] a, input logic [3:0] s,
                              input logic [31:0] d, input int waitCycles, input bit expErr,
                              input logic [31:0] expData);
      int n;
      applyStimulus(1'b1, 1'b1, w, a, 3'b000, 2'b00, s, d, waitCycles > 0);
      expQ.push_back('{expErr, ~w, expData});
      n = 0;
      while (n < 40) begin
         @(negedge clock);
         n++;
         if (wb_ack || wb_err) break;
         @(posedge clock);
         #1;
         waitReq = (n < waitCycles);
      end
      checks++;
      if (n != waitCycles + 2) begin
         errors++;
         $display("[TB] FAIL %s_latency: termination in cycle %0d, required %0d", name, n, waitCycles + 2);
      end
      idleBus();
   endtask

   task automatic beat(input string name, input logic [29:0] a, input logic [2:0] ct, input logic [1:0] b,
                       input bit wr, input bit doPush, input bit pErr, input logic [31:0] pData,
                       input bit expAck);
      applyStimulus(1'b1, 1'b1, 1'b0, a, ct, b, 4'hF, 32'h0, wr);
      if (doPush) expQ.push_back('{pErr, 1'b1, pData});
      checkOutput(name, expAck);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkValue("reset_ack", {31'h0, wb_ack}, 32'h0);
      checkValue("reset_err", {31'h0, wb_err}, 32'h0);
      checkValue("reset_dat", wb_dat_r, 32'h0);

      // Byte lanes, wait states, sel=0 and out-of-range writes
      classicXfer("wr_lanes", 1'b1, 30'h400, 4'b0101, 32'hAABBCCDD, 0, 1'b0, 32'h0);
      classicXfer("rd_lanes", 1'b0, 30'h400, 4'hF, 32'h0, 0, 1'b0, 32'h00BB00DD);
      classicXfer("rd_wait3", 1'b0, 30'h401, 4'hF, 32'h0, 3, 1'b0, 32'h0);
      classicXfer("wr_sel0", 1'b1, 30'h400, 4'b0000, 32'h12345678, 1, 1'b0, 32'h0);
      classicXfer("rd_sel0", 1'b0, 30'h400, 4'hF, 32'h0, 0, 1'b0, 32'h00BB00DD);
      classicXfer("wr_oor", 1'b1, 30'h410, 4'hF, 32'hFFFFFFFF, 0, OorErr, 32'h0);
      classicXfer("rd_alias", 1'b0, 30'h400, 4'hF, 32'h0, 0, 1'b0, 32'h00BB00DD);
      classicXfer("rd_oor", 1'b0, 30'h000, 4'hF, 32'h0, 2, OorErr, 32'h0);

      for (int i = 0; i < 4; i++)
         classicXfer("preload", 1'b1, 30'h404 + 30'(i), 4'hF, 32'(i + 1), i % 2, 1'b0, 32'h0);
      classicXfer("wr_top", 1'b1, 30'h40F, 4'hF, 32'h55, 0, 1'b0, 32'h0);

      // Wrap-4 burst from 406: data 3,4,1,2 back to back
      beat("wrap_acc", 30'h406, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0);
      beat("wrap_b0",  30'h406, 3'b010, 2'b01, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      beat("wrap_b1",  30'h407, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0, 32'd4, 1'b1);
      beat("wrap_b2",  30'h404, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0, 32'd1, 1'b1);
      beat("wrap_b3",  30'h405, 3'b111, 2'b01, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
      idleBus();
      checkOutput("wrap_end", 1'b0);

      // Linear burst whose second beat presents 407 instead of predicted 405
      beat("mis_acc", 30'h404, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
      beat("mis_b0",  30'h404, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      beat("mis_b1",  30'h407, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      beat("mis_reacc", 30'h407, 3'b111, 2'b00, 1'b0, 1'b1, 1'b0, 32'd4, 1'b0);
      beat("mis_ack", 30'h407, 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      idleBus();
      checkOutput("mis_end", 1'b0);

      // Burst stalled by wait_req between beats 0 and 1
      beat("wt_acc", 30'h404, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
      beat("wt_b0",  30'h404, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      beat("wt_stall", 30'h405, 3'b010, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      beat("wt_resume", 30'h405, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0);
      beat("wt_b1",  30'h405, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      beat("wt_b2",  30'h406, 3'b111, 2'b00, 1'b0, 1'b1, 1'b0, 32'd3, 1'b1);
      idleBus();
      checkOutput("wt_end", 1'b0);

      // Linear burst running off the top of the window
      beat("top_acc", 30'h40F, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 32'h55, 1'b0);
      beat("top_b0",  30'h40F, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      beat("top_b1",  30'h410, 3'b111, 2'b00, 1'b0, 1'b1, OorErr, 32'h0, ~OorErr);
      idleBus();
      checkOutput("top_end", 1'b0);

      // cyc dropped in the cycle the ack is due
      beat("drop_acc", 30'h404, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      idleBus();
      checkOutput("drop_due", 1'b0);
      idleBus();
      checkOutput("drop_after", 1'b0);

      // Reset asserted while the first burst ack is on the bus
      beat("rst_acc", 30'h404, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 32'd1, 1'b0);
      @(posedge clock);
      #1 reset = 1'b1;
      checkOutput("rst_ackdue", 1'b1);
      idleBus();
      checkOutput("rst_hold", 1'b0);
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checkValue("rst_dat", wb_dat_r, 32'h0);
      classicXfer("rd_cleared", 1'b0, 30'h404, 4'hF, 32'h0, 0, 1'b0, 32'h0);
      classicXfer("rd_cleared2", 1'b0, 30'h400, 4'hF, 32'h0, 1, 1'b0, 32'h0);

      repeat (2) @(negedge clock);
      checkValue("queue_empty", 32'(expQ.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_mem_responder.md
Name: wb_mem_responder

Overview:
- Wishbone B4 responder (slave) for the 32-bit data or instruction bus of the Minerva core in formal and simulation testbenches.
- Backs a small word-addressed RAM window with byte-lane writes and registered ack.
- Supports classic cycles, incrementing read bursts with wrap modes, externally injected wait states, and out-of-range error responses.
- Replaces free-random ack/data drivers when a bench needs protocol-correct, memory-consistent responses.

Parameters:
- DEPTH_LOG2, 4, log2 of RAM size in 32-bit words (default 16 words).
- BASE_ADR, 30'h400, word address of RAM word 0 (byte address 32'h1000).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_adr  in  30  word address
- wb_dat_w  in  32  write data
- wb_dat_r  out  32  read data, registered
- wb_sel  in  4  byte enables; bit i covers bits 8i+7:8i
- wb_cyc  in  1  cycle valid
- wb_stb  in  1  strobe
- wb_we  in  1  write enable
- wb_cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst; others treated as classic
- wb_bte  in  2  burst type: 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
- wb_ack  out  1  acknowledge
- wb_err  out  1  error termination
- wait_req  in  1  stall request; when high, no beat is accepted this cycle

Behaviour:
- Reset: wb_ack=0, wb_err=0, wb_dat_r=0, FSM=IDLE, all RAM words cleared to 0.
- Accept condition in IDLE: cyc & stb & !wait_req. The beat is accepted at the clock edge ending that cycle.
- Registered termination: ack or err is high in the cycle after acceptance (latency 1). Outputs are gated: wb_ack = ack_q & wb_cyc, and wb_err likewise.
- States:
  - IDLE: on accept, go to RESP.
  - RESP: the termination is visible in this cycle.
  - BURST: continuing read burst.
- Classic, or any write: one ack per accept. From RESP, go to IDLE; no new accept is evaluated in RESP. Maximum classic throughput is 1 beat per 2 cycles.
- Writes:
  - Committed at the accept edge using adr, sel, and dat_w sampled in that cycle.
  - Only lanes with sel set are updated.
  - sel=0 acks with no change.
  - A write with cti=010 is handled as classic.
- Reads: wb_dat_r is loaded at the accept edge with RAM[adr-BASE_ADR]. wb_dat_r holds its value when no read is accepted.
- Read burst (accepted beat has cti=010, !we):
  - In RESP and BURST, compute pred = next address. Linear is adr+1. Wrap-N increments the low log2(N) bits modulo N and keeps the upper bits.
  - If cyc & stb & !wait_req and cti of the current beat is 010, prefetch RAM[pred], keep ack high next cycle, and stay in or enter BURST. This gives back-to-back acks.
  - If wait_req is high, ack drops next cycle and the responder stays in BURST waiting.
  - When the next beat presents, adr must equal pred. On mismatch, drop to IDLE without ack; the beat is re-accepted as classic.
  - A beat with cti=111: final ack, then IDLE.
- Address range: in-range when BASE_ADR <= adr < BASE_ADR+2^DEPTH_LOG2. Wrap arithmetic never leaves the aligned block. Linear bursts that exit the range follow the out-of-range rule.
- cyc deasserted in any state: FSM goes to IDLE at the next edge, ack_q and err_q clear, and no RAM write occurs.
- reset mid-transfer: same as power-on reset, RAM included.
- ack and err are never high together.

Optional Feature:
- Macro: WB_RESP_OOR_ERR_EN.
- Defined: an out-of-range accept terminates with wb_err=1 instead of ack. Read data is 0, the write is dropped, and the FSM returns to IDLE; a burst ends at that beat.
- Undefined: out-of-range beats are acked normally with wb_dat_r=0 and writes ignored. wb_err is tied 0.

Test Plan:
- Write adr=30'h400, sel=4'b0101, dat_w=32'hAABBCCDD; then read 30'h400 -> first ack 1 cycle after accept; read returns 32'h00BB00DD, one ack per request.
- wait_req high for 3 cycles during a stb read of 30'h401 -> ack appears exactly 1 cycle after wait_req falls; data=0 after reset.
- Preload words 30'h404..30'h407 with 1,2,3,4. Read burst cti=010, bte=01, starting 30'h406, cti=111 on the 4th beat -> 4 consecutive acks with data 3,4,1,2, then ack low and FSM IDLE.
- Read burst with adr mismatching pred on beat 2 -> no ack for that cycle; beat re-accepted classic and acked 1 cycle later with correct data.
- cyc dropped in the cycle the ack is due -> wb_ack=0 and no further ack; with WB_RESP_OOR_ERR_EN defined, a read of 30'h000 -> wb_err=1 for 1 cycle, wb_ack=0.
